// File: rtl/fc8_rom_arbiter_if.sv
// fc8_rom_arbiter_if: handshake bundle around the shared cartridge ROM port.
// Carries CPU and sprite req/addr/ack/rdata, ROM addr/cs/data, and busy.
interface fc8_rom_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              spr_req;
    logic [ADDR_W-1:0] spr_addr;
    logic              spr_ack;
    logic [7:0]        spr_rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_cs;
    logic [7:0]        rom_data_in;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_addr, spr_req, spr_addr, rom_data_in,
        output cpu_ack, cpu_rdata, spr_ack, spr_rdata,
        output rom_addr, rom_cs, busy
    );

    modport master (
        output cpu_req, cpu_addr, spr_req, spr_addr, rom_data_in,
        input  cpu_ack, cpu_rdata, spr_ack, spr_rdata,
        input  rom_addr, rom_cs, busy
    );
endinterface

// File: rtl/fc8_rom_arbiter.sv
// fc8_rom_arbiter: serialises CPU and sprite reads onto one cartridge ROM port.
// Ports: clk; rst (async, active-high); bus (slave): cpu/spr req, addr, ack,
// rdata; rom_addr, rom_cs, rom_data_in; busy. CPU has priority, sprite is
// forced after STARVE_LIMIT CPU grants made while it waited.
module fc8_rom_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int ROM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    fc8_rom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(ROM_LATENCY - 1);
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [1:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_cs_q, rom_cs_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              spr_ack_q, spr_ack_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        spr_rdata_q, spr_rdata_d;
    logic              busy_q, busy_d;
    logic              spr_win;

    // owner_q: 1 = sprite, 0 = CPU
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        rom_addr_d  = rom_addr_q;
        rom_cs_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        spr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        spr_rdata_d = spr_rdata_q;
        busy_d      = busy_q;
        spr_win     = bus.spr_req &&
                      (!bus.cpu_req || starve_q >= LIMIT);

        unique case (state_q)
            IDLE: begin
                if (!bus.spr_req) begin
                    starve_d = 4'd0;
                end
                if (bus.cpu_req || bus.spr_req) begin
                    owner_d    = spr_win;
                    rom_addr_d = spr_win ? bus.spr_addr : bus.cpu_addr;
                    if (spr_win) begin
                        starve_d = 4'd0;
                    end else if (bus.spr_req && starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                    // strobe and busy are registered so they line up
                    // with the ISSUE cycle
                    rom_cs_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == 2'd0) begin
                    if (owner_q) begin
                        spr_rdata_d = bus.rom_data_in;
                        spr_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = bus.rom_data_in;
                        cpu_ack_d   = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            rom_addr_q  <= '0;
            rom_cs_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            spr_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            spr_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            rom_addr_q  <= rom_addr_d;
            rom_cs_q    <= rom_cs_d;
            cpu_ack_q   <= cpu_ack_d;
            spr_ack_q   <= spr_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            spr_rdata_q <= spr_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.spr_ack   = spr_ack_q;
    assign bus.spr_rdata = spr_rdata_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_cs    = rom_cs_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fc8_rom_arbiter.sv
// tb_fc8_rom_arbiter: randomized scoreboard bench for fc8_rom_arbiter.
// Drives both requesters and a fixed-latency ROM model through the interface.
module tb_fc8_rom_arbiter;
    localparam int AW  = 20;
    localparam int L   = 3;
    localparam int LIM = 4;

    typedef struct {
        bit          spr;
        logic [19:0] addr;
        logic [7:0]  data;
        int          g;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    exp_t q[$];
    bit   ack_log[$];
    bit   log_en;
    int   next_free;
    int   starve;
    logic [7:0] last_cpu;
    logic [7:0] last_spr;

    bit drv_en;
    int cpu_pct;
    int spr_pct;

    int          cs_cyc;
    logic [19:0] rom_a;

    fc8_rom_arbiter_if #(.ADDR_W(AW)) bus ();

    fc8_rom_arbiter #(
        .ADDR_W      (AW),
        .ROM_LATENCY (L),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'h83;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // ROM model: data is valid only in the cycle whose closing edge should
    // sample it; every other cycle carries junk
    initial begin : rom_model
        cs_cyc = -100;
        rom_a  = '0;
        bus.rom_data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.rom_cs) begin
                cs_cyc = cyc;
                rom_a  = bus.rom_addr;
            end
            if (cyc == cs_cyc + L)
                bus.rom_data_in = rom_byte(rom_a);
            else
                bus.rom_data_in = 8'($urandom);
        end
    end

    // Reference: who is granted, when, and what data comes back
    initial begin : ref_model
        bit s;
        logic [19:0] a;
        forever begin
            @(negedge clk);
            if (!rst && cyc >= next_free) begin
                if (!bus.spr_req) starve = 0;
                if (bus.cpu_req || bus.spr_req) begin
                    s = bus.spr_req && (!bus.cpu_req || starve >= LIM);
                    a = s ? bus.spr_addr : bus.cpu_addr;
                    q.push_back('{spr: s, addr: a, data: rom_byte(a), g: cyc});
                    if (s) starve = 0;
                    else if (bus.spr_req && starve < 15) starve++;
                    next_free = cyc + L + 3;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the head of the queue
    initial begin : monitor
        bit e_cs, e_busy, e_cack, e_sack;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_cs = 0; e_busy = 0; e_cack = 0; e_sack = 0;
                if (q.size() > 0 && q[0].g < cyc) begin
                    e_busy = 1;
                    e_cs   = (cyc == q[0].g + 1);
                    if (cyc == q[0].g + L + 2) begin
                        e_cack = !q[0].spr;
                        e_sack = q[0].spr;
                    end
                    if (cyc <= q[0].g + L + 1)
                        chk("rom_addr", 32'(bus.rom_addr), 32'(q[0].addr));
                end
                chk("busy", 32'(bus.busy), 32'(e_busy));
                chk("rom_cs", 32'(bus.rom_cs), 32'(e_cs));
                chk("cpu_ack", 32'(bus.cpu_ack), 32'(e_cack));
                chk("spr_ack", 32'(bus.spr_ack), 32'(e_sack));
                if (log_en && (bus.cpu_ack || bus.spr_ack))
                    ack_log.push_back(bus.spr_ack);
                if (e_cack || e_sack) begin
                    if (e_cack) last_cpu = q[0].data;
                    else        last_spr = q[0].data;
                    void'(q.pop_front());
                end
                chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(last_cpu));
                chk("spr_rdata", 32'(bus.spr_rdata), 32'(last_spr));
            end
        end
    end

    initial begin : cpu_drv
        bit pend, acked;
        pend = 0;
        forever begin
            @(negedge clk);
            acked = bus.cpu_ack;
            @(posedge clk);
            #1;
            if (drv_en) begin
                if (pend && acked) begin
                    pend = 0;
                    bus.cpu_req = 0;
                end
                if (!pend && $urandom_range(99) < cpu_pct) begin
                    pend = 1;
                    bus.cpu_req  = 1;
                    bus.cpu_addr = 20'($urandom);
                end
            end
        end
    end

    initial begin : spr_drv
        bit pend, acked;
        pend = 0;
        forever begin
            @(negedge clk);
            acked = bus.spr_ack;
            @(posedge clk);
            #1;
            if (drv_en) begin
                if (pend && acked) begin
                    pend = 0;
                    bus.spr_req = 0;
                end
                if (!pend && $urandom_range(99) < spr_pct) begin
                    pend = 1;
                    bus.spr_req  = 1;
                    bus.spr_addr = 20'($urandom);
                end
            end
        end
    end

    task automatic direct(input bit c, input bit s,
                          input logic [19:0] ca, input logic [19:0] sa);
        bit cw, sw;
        int n;
        @(posedge clk);
        #1;
        cw = c; sw = s;
        bus.cpu_req = c; bus.cpu_addr = ca;
        bus.spr_req = s; bus.spr_addr = sa;
        n = 0;
        while ((cw || sw) && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.cpu_ack) cw = 0;
            if (bus.spr_ack) sw = 0;
            @(posedge clk);
            #1;
            if (!cw) bus.cpu_req = 0;
            if (!sw) bus.spr_req = 0;
        end
        chk("direct_done", 32'(cw || sw), 32'd0);
        bus.cpu_req = 0;
        bus.spr_req = 0;
    endtask

    task automatic drain();
        cpu_pct = 0;
        spr_pct = 0;
        repeat (25) @(posedge clk);
        #1;
        drv_en = 0;
        bus.cpu_req = 0;
        bus.spr_req = 0;
        repeat (8) @(posedge clk);
    endtask

    initial begin : main
        int first;
        int n;
        checks = 0; errors = 0; cyc = 0;
        next_free = 0; starve = 0;
        last_cpu = 8'h00; last_spr = 8'h00;
        drv_en = 0; log_en = 0; cpu_pct = 0; spr_pct = 0;
        rst = 1;
        bus.cpu_req = 0; bus.cpu_addr = '0;
        bus.spr_req = 0; bus.spr_addr = '0;

        repeat (2) @(negedge clk);
        chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst_spr_ack", 32'(bus.spr_ack), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_spr_rdata", 32'(bus.spr_rdata), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        repeat (2) @(posedge clk);

        // single CPU read, then simultaneous CPU/sprite
        direct(1, 0, 20'h00026, 20'h0);
        chk("cpu_rdata_a5", 32'(bus.cpu_rdata), 32'h0000_00A5);
        direct(1, 1, 20'h00100, 20'h48000);
        chk("spr_rdata_48000", 32'(bus.spr_rdata), 32'(rom_byte(20'h48000)));

        // both requesters saturated: starvation guard sets the rhythm
        ack_log.delete();
        log_en = 1;
        cpu_pct = 100; spr_pct = 100; drv_en = 1;
        repeat (130) @(posedge clk);
        log_en = 0;
        drain();
        first = -1;
        for (int i = 0; i < ack_log.size(); i++) begin
            if (ack_log[i]) begin
                first = i;
                break;
            end
        end
        chk("first_spr_grant", 32'(first >= 0 && first <= LIM), 32'd1);
        chk("order_len", 32'(ack_log.size() >= first + 11), 32'd1);
        if (first >= 0) begin
            for (int i = 0; i < 11; i++) begin
                if (first + i < ack_log.size())
                    chk("grant_order", 32'(ack_log[first + i]),
                        32'((i % (LIM + 1)) == 0));
            end
        end

        // randomized mix
        cpu_pct = 40; spr_pct = 40; drv_en = 1;
        repeat (1500) @(posedge clk);
        drain();

        // CPU data held while only the sprite is served
        direct(1, 0, 20'h000BF, 20'h0);
        chk("cpu_rdata_3c", 32'(bus.cpu_rdata), 32'h0000_003C);
        spr_pct = 100; drv_en = 1;
        repeat (30) @(posedge clk);
        drain();
        chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'h0000_003C);

        // reset during WAIT of a sprite access
        @(posedge clk);
        #1;
        bus.spr_req  = 1;
        bus.spr_addr = 20'h5A5A5;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.rom_cs) break;
        end
        chk("rst_wait_cs", 32'(bus.rom_cs), 32'd1);
        @(posedge clk);
        #3;
        rst = 1;
        bus.spr_req = 0;
        q.delete();
        starve = 0; next_free = 0;
        last_cpu = 8'h00; last_spr = 8'h00;
        #1;
        chk("arst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("arst_spr_ack", 32'(bus.spr_ack), 32'd0);
        chk("arst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("arst_spr_rdata", 32'(bus.spr_rdata), 32'd0);
        chk("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("arst_rom_cs", 32'(bus.rom_cs), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        repeat (10) @(posedge clk);
        direct(1, 0, 20'h31337, 20'h0);
        chk("post_rst_cpu", 32'(bus.cpu_rdata), 32'(rom_byte(20'h31337)));
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc8_rom_arbiter.md
Name: fc8_rom_arbiter

Overview:
Shares the single physical cartridge ROM read port between the CPU-side fetch path and the sprite engine fetch path. It sits between the MMU's cart-ROM requests, the sprite engine, and fc8_cart_rom. It serialises the reads, tracks the ROM's fixed read latency, and returns data with a one-cycle ack per requester. CPU has priority, and a starvation guard bounds sprite wait.

Parameters:
ADDR_W, 20, physical ROM byte-address width
ROM_LATENCY, 1, cycles from the rom_cs cycle to the edge where rom_data_in is sampled (legal 1..4)
STARVE_LIMIT, 4, consecutive CPU grants with sprite pending before sprite is forced (legal 1..15)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU read request; held with cpu_addr stable until cpu_ack
cpu_addr  in  ADDR_W  CPU physical ROM address
cpu_ack  out  1  one-cycle pulse; cpu_rdata valid this cycle
cpu_rdata  out  8  CPU read data, held until next cpu_ack
spr_req  in  1  sprite read request; same rules as cpu_req
spr_addr  in  ADDR_W  sprite physical ROM address
spr_ack  out  1  one-cycle pulse; spr_rdata valid this cycle
spr_rdata  out  8  sprite read data, held until next spr_ack
rom_addr  out  ADDR_W  address to ROM, registered
rom_cs  out  1  one-cycle ROM read strobe
rom_data_in  in  8  ROM read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1) drives all of the following to 0 and state to IDLE: cpu_ack, spr_ack, cpu_rdata, spr_rdata, rom_addr, rom_cs, busy, starve_cnt, grant_owner.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select the owner. Sprite wins if spr_req && (!cpu_req || starve_cnt >= STARVE_LIMIT); else CPU wins.
  - Latch the owner's address into rom_addr and go to ISSUE.
- ISSUE: rom_cs=1 for exactly this cycle, with rom_addr stable. Load lat_cnt=ROM_LATENCY-1 and go to WAIT.
- WAIT:
  - If lat_cnt==0, sample rom_data_in into the owner's rdata register and go to DONE.
  - Otherwise decrement lat_cnt.
  - Result: rom_data_in is sampled on the edge ending cycle T+1+ROM_LATENCY, where T is the IDLE grant cycle.
- DONE: the owner's ack=1 for this cycle only; the other ack stays 0. Go to IDLE.
- Grants are evaluated only in IDLE. A request still high during DONE is therefore never double-served.
- Latency from grant cycle T: rom_cs at T+1; ack at T+ROM_LATENCY+2. Back-to-back service costs ROM_LATENCY+3 cycles per access.
- starve_cnt (4-bit, saturating at 15):
  - Increments on each CPU grant made while spr_req=1.
  - Clears on a sprite grant, or in any IDLE cycle with spr_req=0.
- rom_addr holds its last value outside ISSUE/WAIT. rom_cs=0 outside ISSUE.
- Request dropped before ack (protocol violation): the access still completes and the ack still pulses. The arbiter takes no other recovery action.
- Address changed mid-access: ignored; the address latched in IDLE is used.
- Reset asserted in ISSUE/WAIT/DONE: the access is abandoned, no ack is issued, and outputs clear immediately (asynchronous).
- No combinational path exists from any input to any output.

Test Plan:
1. ROM_LATENCY=1. cpu_req=1 with cpu_addr=0x00026 at cycle T; model ROM returns 0xA5 -> rom_cs=1 and rom_addr=0x00026 at T+1; cpu_ack=1 and cpu_rdata=0xA5 at T+3; spr_ack stays 0; busy=1 over T+1..T+3.
2. Simultaneous cpu_req (addr 0x00100) and spr_req (addr 0x48000) -> CPU served first; sprite rom_cs occurs in the ISSUE cycle following the CPU DONE. spr_rdata matches ROM[0x48000].
3. STARVE_LIMIT=4, cpu_req and spr_req both held continuously (requesters reissue after each ack) -> grant order C,C,C,C,S,C,C,C,C,S. starve_cnt returns to 0 after each S.
4. ROM_LATENCY=3 -> rom_cs at T+1, ack at T+5; a ROM model that changes rom_data_in at T+3 proves sampling occurs only at the T+4 edge.
5. rst pulsed high during WAIT of a sprite access -> spr_ack never pulses; all outputs read 0 asynchronously. After release, a new cpu_req is served with nominal latency.
6. Hold check: after cpu_ack with 0x3C, issue only sprite reads for 10 cycles -> cpu_rdata remains 0x3C throughout.
